// File: rtl/ansi_key_decoder.sv
// ansi_key_decoder
//   Parses the raw keyboard byte stream into single-cycle key events:
//   printable characters, Space, Enter, bare ESC, Alt+key (ESC prefix) and
//   CSI escape sequences (arrows, Home/End, Delete, anything else reported
//   as UNKNOWN with its final byte).
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   inp[7:0]   raw byte, 8'h00 = no byte this cycle
//   key_valid  one-cycle event strobe
//   key_code   event code (NONE/CHAR/SPACE/ENTER/ESC/arrows/HOME/END/DEL/ALT/UNKNOWN)
//   key_char   byte for CHAR/ALT, final byte for UNKNOWN, else 0
//   key_param  first decimal CSI parameter (saturating at 255), else 0
//   err        one-cycle strobe when a sequence is aborted
//
// All outputs are registered: an event shows up the cycle after the edge
// that samples its terminating byte.
module ansi_key_decoder #(
  parameter int ESC_TIMEOUT   = 4,
  parameter int MAX_PARAM_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inp,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] key_char,
  output logic [7:0] key_param,
  output logic       err
);

  localparam int CW = $clog2(ESC_TIMEOUT + 1);
  localparam int LW = (MAX_PARAM_LEN < 1) ? 1 : $clog2(MAX_PARAM_LEN + 1);
  localparam logic [CW-1:0] TO_VAL  = CW'(ESC_TIMEOUT);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PARAM_LEN);

  localparam logic [7:0] B_ESC  = 8'h1B;
  localparam logic [7:0] B_LBR  = 8'h5B;
  localparam logic [7:0] B_SEMI = 8'h3B;

  localparam logic [3:0] K_NONE  = 4'd0;
  localparam logic [3:0] K_CHAR  = 4'd1;
  localparam logic [3:0] K_SPACE = 4'd2;
  localparam logic [3:0] K_ENTER = 4'd3;
  localparam logic [3:0] K_ESC   = 4'd4;
  localparam logic [3:0] K_UP    = 4'd5;
  localparam logic [3:0] K_DOWN  = 4'd6;
  localparam logic [3:0] K_RIGHT = 4'd7;
  localparam logic [3:0] K_LEFT  = 4'd8;
  localparam logic [3:0] K_HOME  = 4'd9;
  localparam logic [3:0] K_END   = 4'd10;
  localparam logic [3:0] K_DEL   = 4'd11;
  localparam logic [3:0] K_ALT   = 4'd12;
  localparam logic [3:0] K_UNK   = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_ESC, S_CSI} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic [7:0]    param, param_d;
  logic [LW-1:0] len, len_d;
  logic          semi, semi_d;       // ';' seen: stop accumulating digits
  logic          tmo;
  logic [11:0]   acc;

  logic          ev_valid;
  logic [3:0]    ev_code;
  logic [7:0]    ev_char;
  logic [7:0]    ev_param;
  logic          ev_err;

  // byte classes used while inside a CSI
  logic is_digit, is_pbyte, is_final, is_ctrl;
  assign is_digit = (inp >= 8'h30) && (inp <= 8'h39);
  assign is_pbyte = (inp >= 8'h20) && (inp <= 8'h3F);
  assign is_final = (inp >= 8'h40) && (inp <= 8'h7E);
  assign is_ctrl  = (inp != 8'h00) && (inp < 8'h20) && (inp != B_ESC);

  // idle counter saturates at the timeout value; timeout fires on the
  // zero byte that brings it there
  assign cnt_inc = (cnt == TO_VAL) ? cnt : cnt + CW'(1);
  assign tmo     = (inp == 8'h00) && (cnt_inc == TO_VAL);

  // 12-bit intermediate so param*10+digit cannot wrap before clamping
  assign acc = {4'd0, param} * 12'd10 + {8'd0, inp[3:0]};

  // ---------------------------------------------------------------------
  // state register (also holds the registered event outputs)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      param     <= '0;
      len       <= '0;
      semi      <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= K_NONE;
      key_char  <= '0;
      key_param <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      param     <= param_d;
      len       <= len_d;
      semi      <= semi_d;
      key_valid <= ev_valid;
      key_code  <= ev_code;
      key_char  <= ev_char;
      key_param <= ev_param;
      err       <= ev_err;
    end
  end

  // ---------------------------------------------------------------------
  // next state and sequence datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    param_d = param;
    len_d   = len;
    semi_d  = semi;
    unique case (state)
      S_IDLE: begin
        if (inp == B_ESC) begin
          state_d = S_ESC;
          cnt_d   = '0;
        end
      end
      S_ESC: begin
        if (inp == 8'h00) begin
          cnt_d = cnt_inc;
          if (tmo) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (inp == B_LBR) begin
          state_d = S_CSI;
          cnt_d   = '0;
          param_d = '0;
          len_d   = '0;
          semi_d  = 1'b0;
        end else if (inp == B_ESC) begin
          cnt_d = '0;               // previous ESC resolved, new one pending
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CSI: begin
        cnt_d = '0;
        if (inp == 8'h00) begin
          cnt_d = cnt_inc;
          if (tmo) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (inp == B_ESC) begin
          state_d = S_ESC;          // abandon CSI, new sequence starts
        end else if (is_ctrl) begin
          state_d = S_IDLE;
        end else if (is_pbyte) begin
          if (len == LEN_MAX) begin
            state_d = S_IDLE;       // too long: abort
          end else begin
            len_d = len + LW'(1);
            if (inp == B_SEMI) semi_d = 1'b1;
            if (is_digit && !semi) param_d = (acc > 12'd255) ? 8'hFF : acc[7:0];
          end
        end else if (is_final) begin
          state_d = S_IDLE;
        end
        // 0x7F..0xFF inside a CSI are dropped without effect
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // event decode (registered on the next edge)
  // ---------------------------------------------------------------------
  always_comb begin
    ev_valid = 1'b0;
    ev_code  = K_NONE;
    ev_char  = '0;
    ev_param = '0;
    ev_err   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (inp != 8'h00 && inp != B_ESC) begin
          ev_valid = 1'b1;
          if (inp == 8'h20) begin
            ev_code = K_SPACE;
          end else if (inp == 8'h0A || inp == 8'h0D) begin
            ev_code = K_ENTER;
          end else begin
            ev_code = K_CHAR;
            ev_char = inp;
          end
        end
      end
      S_ESC: begin
        if (tmo || inp == B_ESC) begin
          ev_valid = 1'b1;
          ev_code  = K_ESC;
        end else if (inp != 8'h00 && inp != B_LBR) begin
          ev_valid = 1'b1;
          ev_code  = K_ALT;
          ev_char  = inp;
        end
      end
      S_CSI: begin
        if (tmo || inp == B_ESC || is_ctrl || (is_pbyte && len == LEN_MAX)) begin
          ev_err = 1'b1;
        end else if (is_final) begin
          ev_valid = 1'b1;
          ev_param = param;
          case (inp)
            8'h41: ev_code = K_UP;
            8'h42: ev_code = K_DOWN;
            8'h43: ev_code = K_RIGHT;
            8'h44: ev_code = K_LEFT;
            8'h48: ev_code = K_HOME;
            8'h46: ev_code = K_END;
            8'h7E: begin
              case (param)
                8'd1:    ev_code = K_HOME;
                8'd3:    ev_code = K_DEL;
                8'd4:    ev_code = K_END;
                default: begin
                  ev_code = K_UNK;
                  ev_char = inp;
                end
              endcase
            end
            default: begin
              ev_code = K_UNK;
              ev_char = inp;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ansi_key_decoder.sv
// Self-checking bench for ansi_key_decoder: directed sequences from the
// test plan followed by biased random bytes, every cycle compared against
// a queue-based reference model of the decoding rules.
module tb_ansi_key_decoder;

  localparam int TO = 4;
  localparam int ML = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inp;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] key_char;
  logic [7:0] key_param;
  logic       err;

  ansi_key_decoder #(.ESC_TIMEOUT(TO), .MAX_PARAM_LEN(ML)) dut (
    .clk(clk), .rst(rst), .inp(inp),
    .key_valid(key_valid), .key_code(key_code), .key_char(key_char),
    .key_param(key_param), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // pending sequence bytes: empty = idle, {ESC} = lone escape,
  // {ESC,'[',...} = inside CSI with its parameter bytes
  logic [7:0] q[$];
  int         idle = 0;

  function automatic logic [21:0] ev(logic v, logic [3:0] c, logic [7:0] ch,
                                     logic [7:0] p, logic e);
    return {v, c, ch, p, e};
  endfunction

  function automatic logic [21:0] obs();
    return {key_valid, key_code, key_char, key_param, err};
  endfunction

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got v=%0b code=%0d char=%02h param=%0d err=%0b, want v=%0b code=%0d char=%02h param=%0d err=%0b",
               tag, got[21], got[20:17], got[16:9], got[8:1], got[0],
               exp[21], exp[20:17], exp[16:9], exp[8:1], exp[0]);
    end
  endtask

  // first decimal parameter of the CSI body, clamped to 255
  function automatic int csi_param(input logic [7:0] s[$]);
    int p = 0;
    for (int i = 2; i < s.size(); i++) begin
      if (s[i] == 8'h3B) break;
      if (s[i] >= 8'h30 && s[i] <= 8'h39) begin
        p = p * 10 + int'(s[i] - 8'h30);
        if (p > 255) p = 255;
      end
    end
    return p;
  endfunction

  task automatic model(input logic [7:0] b, output logic [21:0] e);
    int p;
    e = '0;
    if (q.size() == 0) begin
      if (b == 8'h1B) begin
        q.push_back(b);
        idle = 0;
      end else if (b == 8'h20) e = ev(1, 2, 0, 0, 0);
      else if (b == 8'h0A || b == 8'h0D) e = ev(1, 3, 0, 0, 0);
      else if (b != 8'h00) e = ev(1, 1, b, 0, 0);
    end else if (q.size() == 1) begin
      if (b == 8'h00) begin
        idle++;
        if (idle == TO) begin
          e = ev(1, 4, 0, 0, 0);
          q.delete();
        end
      end else if (b == 8'h5B) begin
        q.push_back(b);
        idle = 0;
      end else if (b == 8'h1B) begin
        e = ev(1, 4, 0, 0, 0);
        idle = 0;
      end else begin
        e = ev(1, 12, b, 0, 0);
        q.delete();
      end
    end else begin
      if (b == 8'h00) begin
        idle++;
        if (idle == TO) begin
          e = ev(0, 0, 0, 0, 1);
          q.delete();
        end
      end else begin
        idle = 0;
        if (b == 8'h1B) begin
          e = ev(0, 0, 0, 0, 1);
          q.delete();
          q.push_back(b);
        end else if (b < 8'h20) begin
          e = ev(0, 0, 0, 0, 1);
          q.delete();
        end else if (b <= 8'h3F) begin
          if (q.size() - 2 >= ML) begin
            e = ev(0, 0, 0, 0, 1);
            q.delete();
          end else q.push_back(b);
        end else if (b <= 8'h7E) begin
          p = csi_param(q);
          if      (b == "A") e = ev(1, 5, 0, p[7:0], 0);
          else if (b == "B") e = ev(1, 6, 0, p[7:0], 0);
          else if (b == "C") e = ev(1, 7, 0, p[7:0], 0);
          else if (b == "D") e = ev(1, 8, 0, p[7:0], 0);
          else if (b == "H") e = ev(1, 9, 0, p[7:0], 0);
          else if (b == "F") e = ev(1, 10, 0, p[7:0], 0);
          else if (b == "~" && p == 1) e = ev(1, 9, 0, p[7:0], 0);
          else if (b == "~" && p == 3) e = ev(1, 11, 0, p[7:0], 0);
          else if (b == "~" && p == 4) e = ev(1, 10, 0, p[7:0], 0);
          else e = ev(1, 13, b, p[7:0], 0);
          q.delete();
        end
        // bytes >= 0x7F inside a CSI are ignored
      end
    end
  endtask

  task automatic step(input logic [7:0] b, input string tag);
    logic [21:0] e;
    inp = b;
    @(posedge clk);
    #1;
    model(b, e);
    chk(tag, obs(), e);
  endtask

  task automatic send(input logic [7:0] s[$], input string tag);
    foreach (s[i]) step(s[i], tag);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] tbl [0:23] = '{8'h00, 8'h00, 8'h00, 8'h1B, 8'h1B, 8'h5B, 8'h5B,
                               "1", "3", "4", "9", "0", ";", "~", "A", "D",
                               "H", "F", "x", 8'h20, 8'h0D, 8'h05, "<", 8'h90};
    if ($urandom_range(0, 9) < 8) return tbl[$urandom_range(0, 23)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    rst = 1'b1;
    inp = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", obs(), '0);
    rst = 1'b0;

    send('{"x", 8'h20, 8'h0D}, "char_space_enter");
    send('{8'h1B, "[", "A", 8'h1B, "[", "D"}, "up_left");
    send('{8'h1B, "[", "3", "~"}, "del");
    send('{8'h1B, "[", "9", "9", "9", "~"}, "unk_sat");
    send('{8'h1B, 8'h00, 8'h00, 8'h00, 8'h00}, "esc_timeout");
    send('{8'h1B, "q"}, "alt");
    send('{8'h1B, "[", "1", ";", "5", "5", "A"}, "csi_abort");
    send('{8'h1B, "[", "1", "~", 8'h1B, "[", "4", "~"}, "home_end_tilde");
    send('{8'h1B, "[", 8'h00, 8'h00, 8'h00, 8'h00}, "csi_timeout");
    send('{8'h1B, 8'h1B, "[", "2", 8'h1B, "C", 8'h1B, "[", 8'h07, "z"}, "esc_ctrl");

    // async reset clears a pending event immediately
    step("x", "pre_async");
    rst = 1'b1;
    #1;
    chk("async_rst", obs(), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    idle = 0;

    // reset in the middle of a CSI discards it
    send('{8'h1B, "["}, "pre_mid_rst");
    rst = 1'b1;
    inp = 8'h00;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("mid_rst", obs(), '0);
    end
    rst = 1'b0;
    q.delete();
    idle = 0;
    step("A", "post_rst_char");

    for (int i = 0; i < 4000; i++) step(pick(), "rnd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
